// File: rtl/oam_dma_controller_if.sv
// Handshake and memory-port bundle between the OAM DMA engine and the rest of the system.
// master = the DMA controller, slave = CPU/arbiter/memory side.
interface oam_dma_controller_if;
    logic        dma_start;
    logic [7:0]  dma_src_hi;
    logic        bus_grant;
    logic        bus_req;
    logic        busy;
    logic        done;
    logic [15:0] mem_address;
    logic        mem_OE;
    logic        mem_WE;
    logic [7:0]  mem_wdata;
    logic        mem_drive;
    logic [7:0]  mem_rdata;

    modport master (
        input  dma_start, dma_src_hi, bus_grant, mem_rdata,
        output bus_req, busy, done, mem_address, mem_OE, mem_WE, mem_wdata, mem_drive
    );

    modport slave (
        output dma_start, dma_src_hi, bus_grant, mem_rdata,
        input  bus_req, busy, done, mem_address, mem_OE, mem_WE, mem_wdata, mem_drive
    );
endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA engine: copies BYTE_COUNT bytes from {src_hi, 8'h00} to DEST_BASE, four cycles per
// byte (read address, read, write address, write), pausing whenever the bus grant is withdrawn.
module oam_dma_controller #(
    parameter int unsigned BYTE_COUNT = 160,
    parameter logic [15:0] DEST_BASE  = 16'hFE00
) (
    input logic                  clk,
    input logic                  rst,
    oam_dma_controller_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] RD_ADDR = 3'd2;
    localparam logic [2:0] RD_DATA = 3'd3;
    localparam logic [2:0] WR_ADDR = 3'd4;
    localparam logic [2:0] WR_DATA = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    localparam logic [7:0] LAST_IDX = 8'(BYTE_COUNT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] byte_q, byte_d;

    logic        req, bsy, dn, oe, we, drv;
    logic [15:0] addr;
    logic [7:0]  wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 8'h00;
            src_hi_q <= 8'h00;
            byte_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            src_hi_q <= src_hi_d;
            byte_q   <= byte_d;
        end
    end

    // A start strobe restarts from any state, including mid-transfer and the DONE cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        src_hi_d = src_hi_q;
        byte_d   = byte_q;
        if (bus.dma_start) begin
            src_hi_d = bus.dma_src_hi;
            idx_d    = 8'h00;
            state_d  = REQ;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                REQ:     if (bus.bus_grant) state_d = RD_ADDR;
                RD_ADDR: if (bus.bus_grant) state_d = RD_DATA;
                RD_DATA: begin
                    if (bus.bus_grant) begin
                        byte_d  = bus.mem_rdata;
                        state_d = WR_ADDR;
                    end
                end
                WR_ADDR: if (bus.bus_grant) state_d = WR_DATA;
                WR_DATA: begin
                    if (bus.bus_grant) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 8'd1;
                            state_d = RD_ADDR;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are gated by the grant; the address stays put so a stall resumes seamlessly.
    always_comb begin
        req   = 1'b0;
        bsy   = 1'b0;
        dn    = 1'b0;
        oe    = 1'b0;
        we    = 1'b0;
        drv   = 1'b0;
        addr  = 16'h0000;
        wdata = 8'h00;
        case (state_q)
            REQ: begin
                req = 1'b1;
                bsy = 1'b1;
            end
            RD_ADDR, RD_DATA: begin
                req  = 1'b1;
                bsy  = 1'b1;
                addr = {src_hi_q, idx_q};
                oe   = (state_q == RD_DATA) && bus.bus_grant;
            end
            WR_ADDR, WR_DATA: begin
                req   = 1'b1;
                bsy   = 1'b1;
                addr  = DEST_BASE + {8'h00, idx_q};
                wdata = byte_q;
                drv   = bus.bus_grant;
                we    = (state_q == WR_DATA) && bus.bus_grant;
            end
            DONE:    dn = 1'b1;
            default: ;
        endcase
    end

    assign bus.bus_req     = req;
    assign bus.busy        = bsy;
    assign bus.done        = dn;
    assign bus.mem_address = addr;
    assign bus.mem_OE      = oe;
    assign bus.mem_WE      = we;
    assign bus.mem_wdata   = wdata;
    assign bus.mem_drive   = drv;
endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: a registered-address memory model feeds two instances
// (160 and 256 bytes); expected OAM contents and done timing come from the transfer rules.
module tb_oam_dma_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    oam_dma_controller_if i160 ();
    oam_dma_controller_if i256 ();

    oam_dma_controller #(.BYTE_COUNT(160), .DEST_BASE(16'hFE00)) dut160 (
        .clk(clk), .rst(rst), .bus(i160)
    );
    oam_dma_controller #(.BYTE_COUNT(256), .DEST_BASE(16'hFE00)) dut256 (
        .clk(clk), .rst(rst), .bus(i256)
    );

    // Memory model: address registered on clk, access happens in the following cycle.
    logic [7:0]  src_mem [65536];
    logic [7:0]  dst160 [256];
    logic [7:0]  dst256 [256];
    logic [15:0] a160_q, a256_q;
    int          bad_wr160 = 0;
    int          bad_wr256 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a160_q <= 16'h0000;
            a256_q <= 16'h0000;
        end else begin
            a160_q <= i160.mem_address;
            a256_q <= i256.mem_address;
            if (i160.mem_WE) begin
                if (a160_q[15:8] == 8'hFE) dst160[a160_q[7:0]] <= i160.mem_wdata;
                else bad_wr160 <= bad_wr160 + 1;
            end
            if (i256.mem_WE) begin
                if (a256_q[15:8] == 8'hFE) dst256[a256_q[7:0]] <= i256.mem_wdata;
                else bad_wr256 <= bad_wr256 + 1;
            end
        end
    end

    assign i160.mem_rdata = i160.mem_OE ? src_mem[a160_q] : 8'h00;
    assign i256.mem_rdata = i256.mem_OE ? src_mem[a256_q] : 8'h00;

    task automatic test_reset();
        #3;
        checks++;
        if ({i160.bus_req, i160.busy, i160.done, i160.mem_OE, i160.mem_WE, i160.mem_drive,
             i160.mem_address, i160.mem_wdata} !== 30'd0) begin
            failures++;
            $display("FAIL reset160: got req=%b busy=%b done=%b addr=%h wdata=%h required all 0",
                     i160.bus_req, i160.busy, i160.done, i160.mem_address, i160.mem_wdata);
        end
        checks++;
        if ({i256.bus_req, i256.busy, i256.done, i256.mem_OE, i256.mem_WE, i256.mem_drive,
             i256.mem_address, i256.mem_wdata} !== 30'd0) begin
            failures++;
            $display("FAIL reset256: got req=%b busy=%b addr=%h required all 0",
                     i256.bus_req, i256.busy, i256.mem_address);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_copy();
        int cyc, done_cnt, done_at, bad, errs;
        logic [15:0] t_addr [4];
        logic        t_oe [4];
        logic        t_we [4];
        logic        t_drv [4];
        logic [7:0]  t_wd [4];
        for (int i = 0; i < 160; i++) src_mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
        cyc = 0; done_cnt = 0; done_at = 0; bad = 0; errs = 0;
        i160.dma_src_hi = 8'hC0;
        i160.dma_start  = 1'b1;
        while (cyc < 700) begin
            @(posedge clk); #1;
            cyc++;
            i160.dma_start = 1'b0;
            if (cyc >= 2 && cyc <= 5) begin
                t_addr[cyc-2] = i160.mem_address;
                t_oe[cyc-2]   = i160.mem_OE;
                t_we[cyc-2]   = i160.mem_WE;
                t_drv[cyc-2]  = i160.mem_drive;
                t_wd[cyc-2]   = i160.mem_wdata;
            end
            if ((i160.mem_OE && i160.mem_WE) || (i160.mem_OE && i160.mem_drive)) bad++;
            if (i160.done) begin
                done_cnt++;
                if (done_at == 0) done_at = cyc;
            end
        end
        checks++;
        if ({t_addr[0], t_oe[0], t_we[0], t_addr[1], t_oe[1], t_we[1]} !==
            {16'hC000, 1'b0, 1'b0, 16'hC000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL byte0_read: got %h/%b%b %h/%b%b required c000/00 c000/10",
                     t_addr[0], t_oe[0], t_we[0], t_addr[1], t_oe[1], t_we[1]);
        end
        checks++;
        if ({t_addr[2], t_we[2], t_drv[2], t_wd[2], t_addr[3], t_we[3], t_drv[3], t_wd[3]} !==
            {16'hFE00, 1'b0, 1'b1, 8'h5A, 16'hFE00, 1'b1, 1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL byte0_write: got %h we=%b d=%b wd=%h / %h we=%b d=%b wd=%h",
                     t_addr[2], t_we[2], t_drv[2], t_wd[2], t_addr[3], t_we[3], t_drv[3],
                     t_wd[3]);
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 2 + 4 * 160) begin
            failures++;
            $display("FAIL basic_done: got count=%0d cycle=%0d required count=1 cycle=%0d",
                     done_cnt, done_at, 2 + 4 * 160);
        end
        for (int i = 0; i < 160; i++) if (dst160[i] !== (8'(i) ^ 8'h5A)) errs++;
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL basic_data: got %0d wrong bytes required 0", errs);
        end
        checks++;
        if (i160.busy !== 1'b0 || bad !== 0 || bad_wr160 !== 0) begin
            failures++;
            $display("FAIL basic_idle: got busy=%b overlap=%0d stray_wr=%0d required 0 0 0",
                     i160.busy, bad, bad_wr160);
        end
    endtask

    task automatic test_grant_stall();
        int cyc, done_at, stall_bad, errs;
        logic       stalled;
        logic [7:0] hi;
        hi = 8'($urandom_range(8'h10, 8'hEF));
        for (int i = 0; i < 160; i++) src_mem[{hi, 8'(i)}] = 8'($urandom);
        cyc = 0; done_at = 0; stall_bad = 0; errs = 0; stalled = 1'b0;
        i160.dma_src_hi = hi;
        i160.dma_start  = 1'b1;
        while (cyc < 720 && done_at == 0) begin
            @(posedge clk); #1;
            cyc++;
            i160.dma_start = 1'b0;
            if (i160.done) done_at = cyc;
            if (!stalled && i160.mem_OE && i160.mem_address == {hi, 8'd37}) begin
                stalled = 1'b1;
                i160.bus_grant = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    if (i160.mem_OE || i160.mem_WE || i160.mem_drive ||
                        i160.mem_address !== {hi, 8'd37}) stall_bad++;
                    @(posedge clk); #1;
                    cyc++;
                end
                i160.bus_grant = 1'b1;
            end
        end
        checks++;
        if (stall_bad !== 0 || !stalled) begin
            failures++;
            $display("FAIL stall_outputs: got bad=%0d seen=%b required bad=0 seen=1",
                     stall_bad, stalled);
        end
        checks++;
        if (done_at !== 2 + 4 * 160 + 5) begin
            failures++;
            $display("FAIL stall_done: got cycle=%0d required %0d", done_at, 2 + 4 * 160 + 5);
        end
        for (int i = 0; i < 160; i++) if (dst160[i] !== src_mem[{hi, 8'(i)}]) errs++;
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL stall_data: got %0d wrong bytes required 0", errs);
        end
    endtask

    task automatic test_restart();
        int cyc, done_cnt, done_at, rc, req_gap, errs;
        logic fired;
        for (int i = 0; i < 160; i++) begin
            src_mem[16'hC000 + i] = 8'($urandom);
            src_mem[16'hD000 + i] = 8'($urandom);
        end
        cyc = 0; done_cnt = 0; done_at = 0; rc = 0; req_gap = 0; errs = 0; fired = 1'b0;
        i160.dma_src_hi = 8'hC0;
        i160.dma_start  = 1'b1;
        while (cyc < 800) begin
            @(posedge clk); #1;
            cyc++;
            i160.dma_start = 1'b0;
            if (i160.done) begin
                done_cnt++;
                if (done_at == 0) done_at = cyc;
            end else if (done_cnt == 0 && i160.bus_req !== 1'b1) begin
                req_gap++;
            end
            if (!fired && i160.mem_address == 16'hC00A && !i160.mem_OE) begin
                fired = 1'b1;
                rc = cyc;
                i160.dma_src_hi = 8'hD0;
                i160.dma_start  = 1'b1;
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== rc + 2 + 4 * 160 || !fired) begin
            failures++;
            $display("FAIL restart_done: got count=%0d cycle=%0d required count=1 cycle=%0d",
                     done_cnt, done_at, rc + 2 + 4 * 160);
        end
        checks++;
        if (req_gap !== 0) begin
            failures++;
            $display("FAIL restart_req: got %0d cycles with bus_req low required 0", req_gap);
        end
        for (int i = 0; i < 160; i++) if (dst160[i] !== src_mem[16'hD000 + i]) errs++;
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL restart_data: got %0d wrong bytes required 0", errs);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, errs, stray;
        logic       fired;
        logic [7:0] hi;
        logic [7:0] snap [256];
        hi = 8'($urandom_range(8'h10, 8'hEF));
        for (int i = 0; i < 160; i++) src_mem[{hi, 8'(i)}] = 8'($urandom);
        cyc = 0; errs = 0; stray = 0; fired = 1'b0;
        i160.dma_src_hi = hi;
        i160.dma_start  = 1'b1;
        while (cyc < 700 && !fired) begin
            @(posedge clk); #1;
            cyc++;
            i160.dma_start = 1'b0;
            if (i160.mem_address == {hi, 8'd80} && !i160.mem_OE) fired = 1'b1;
        end
        for (int i = 0; i < 256; i++) snap[i] = dst160[i];
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!fired || {i160.bus_req, i160.busy, i160.done, i160.mem_OE, i160.mem_WE,
                       i160.mem_drive, i160.mem_address, i160.mem_wdata} !== 30'd0) begin
            failures++;
            $display("FAIL reset_async: got req=%b busy=%b addr=%h wdata=%h required all 0",
                     i160.bus_req, i160.busy, i160.mem_address, i160.mem_wdata);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (i160.busy || i160.bus_req || i160.done || i160.mem_address !== 16'h0000) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL reset_idle: got %0d non-idle cycles required 0", stray);
        end
        for (int i = 81; i < 160; i++) if (dst160[i] !== snap[i]) errs++;
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL reset_oam: got %0d changed bytes required 0", errs);
        end
    endtask

    task automatic test_random_grant();
        int cyc, done_at, lows, errs, bad;
        logic [7:0] hi;
        for (int r = 0; r < 2; r++) begin
            hi = 8'($urandom_range(8'h10, 8'hEF));
            for (int i = 0; i < 160; i++) src_mem[{hi, 8'(i)}] = 8'($urandom);
            cyc = 0; done_at = 0; lows = 0; errs = 0; bad = 0;
            i160.dma_src_hi = hi;
            i160.dma_start  = 1'b1;
            while (cyc < 1500 && done_at == 0) begin
                @(posedge clk); #1;
                cyc++;
                i160.dma_start = 1'b0;
                if ((i160.mem_OE && i160.mem_WE) || (i160.mem_OE && i160.mem_drive)) bad++;
                if (i160.done) begin
                    done_at = cyc;
                end else begin
                    i160.bus_grant = ($urandom_range(0, 3) != 0);
                    if (!i160.bus_grant) lows++;
                end
            end
            i160.bus_grant = 1'b1;
            checks++;
            if (done_at !== 2 + 4 * 160 + lows) begin
                failures++;
                $display("FAIL rand_done[%0d]: got cycle=%0d required %0d", r, done_at,
                         2 + 4 * 160 + lows);
            end
            for (int i = 0; i < 160; i++) if (dst160[i] !== src_mem[{hi, 8'(i)}]) errs++;
            checks++;
            if (errs !== 0 || bad !== 0) begin
                failures++;
                $display("FAIL rand_data[%0d]: got wrong=%0d overlap=%0d required 0 0",
                         r, errs, bad);
            end
        end
    endtask

    task automatic test_wrap_256();
        int cyc, done_cnt, done_at, off_page, errs;
        logic [15:0] last_wr;
        for (int i = 0; i < 256; i++) src_mem[16'h8000 + i] = 8'($urandom);
        cyc = 0; done_cnt = 0; done_at = 0; off_page = 0; errs = 0; last_wr = 16'h0000;
        i256.dma_src_hi = 8'h80;
        i256.dma_start  = 1'b1;
        while (cyc < 1100) begin
            @(posedge clk); #1;
            cyc++;
            i256.dma_start = 1'b0;
            if (i256.mem_OE && i256.mem_address[15:8] !== 8'h80) off_page++;
            if (i256.mem_WE) last_wr = i256.mem_address;
            if (i256.done) begin
                done_cnt++;
                if (done_at == 0) done_at = cyc;
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 2 + 4 * 256) begin
            failures++;
            $display("FAIL wrap_done: got count=%0d cycle=%0d required count=1 cycle=%0d",
                     done_cnt, done_at, 2 + 4 * 256);
        end
        checks++;
        if (last_wr !== 16'hFEFF || off_page !== 0 || bad_wr256 !== 0) begin
            failures++;
            $display("FAIL wrap_addr: got last=%h off_page=%0d stray=%0d required feff 0 0",
                     last_wr, off_page, bad_wr256);
        end
        for (int i = 0; i < 256; i++) if (dst256[i] !== src_mem[16'h8000 + i]) errs++;
        checks++;
        if (errs !== 0 || i256.busy !== 1'b0) begin
            failures++;
            $display("FAIL wrap_data: got wrong=%0d busy=%b required 0 0", errs, i256.busy);
        end
    endtask

    initial begin
        i160.dma_start  = 1'b0;
        i160.dma_src_hi = 8'h00;
        i160.bus_grant  = 1'b1;
        i256.dma_start  = 1'b0;
        i256.dma_src_hi = 8'h00;
        i256.bus_grant  = 1'b1;
        test_reset();
        test_basic_copy();
        test_grant_stall();
        test_restart();
        test_reset_mid();
        test_random_grant();
        test_wrap_256();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
